ppm_frame_ctrl: RTL
===================

// Module: ppm_frame_ctrl
// PURPOSE
//  Frame sequencer for the PPM transmitter. Takes a frame request (length) and a byte stream from the host.
//  Pulses the SOF generator and waits for its done flag, then 4-PPM-encodes each byte onto the line and appends an EOF marker.
//  Owns the single tx line: muxes the SOF generator output in during SOF, drives the line itself otherwise.
// PARAMETERS
//  SLOT_CYC   16  clock cycles per PPM slot (>=2); 4 slots per symbol, 2 bits per symbol
//  EOF_SLOTS  2   slots the line is held low for the EOF marker (>=1)
//  GAP_SLOTS  4   idle-high slots after EOF before the next frame may start (>=1)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  synchronous reset, active low
//  frame_start  in   1  one-cycle request; sampled only in IDLE
//  frame_len    in   8  byte count, latched with frame_start; 0 = EOF-only frame
//  data_in      in   8  payload byte
//  data_valid   in   1  data_in valid
//  data_ready   out  1  byte taken when data_valid & data_ready
//  control_sof  out  1  one-cycle pulse to the SOF generator
//  sof_in       in   1  SOF generator line output (idle high)
//  sof_done     in   1  SOF generator completion flag
//  tx_line      out  1  PPM line, idle high, pulse = low
//  busy         out  1  high in every state except IDLE
//  err_underrun out  1  one-cycle pulse on byte underrun
// BEHAVIOUR
//  Reset (rst_n low at a clk edge): state=IDLE, tx_line=1, control_sof=0, data_ready=0, busy=0, err_underrun=0, all counters 0.
//  Reset mid-frame aborts at once: no EOF is sent and the line returns high on the next edge.
//  States: IDLE -> SOF_REQ -> SOF_WAIT -> DATA -> [PAR] -> EOF -> GAP -> IDLE.
//  IDLE: frame_start=1 latches frame_len, goes to SOF_REQ; frame_start in any other state is ignored.
//  SOF_REQ: control_sof=1 for exactly one cycle, then SOF_WAIT.
//  SOF_WAIT: tx_line follows sof_in combinationally; leave on the first cycle sof_done=1.
//   Go to DATA if len>0, else to EOF (or to PAR if the macro is enabled).
//  DATA: byte fetch happens on the first cycle of DATA and on the cycle after a byte's last slot.
//   At fetch, data_ready=1 for one cycle. If data_valid=1, load the shift register and start symbols on the next cycle.
//   If data_valid=0, pulse err_underrun and go to EOF; bytes already sent stand.
//  Symbol s = the next 2 bits, MSB first (4 symbols per byte).
//   Slot counter runs 0..SLOT_CYC-1 and slot index 0..3; tx_line=0 during slot s, else 1.
//   tx_line is registered: slot k of symbol s occupies cycles [k*SLOT_CYC, (k+1)*SLOT_CYC) after symbol start.
//   Byte time is 16*SLOT_CYC cycles plus 1 fetch cycle.
//   After the last byte of len, go to EOF (or PAR).
//  EOF: tx_line=0 for EOF_SLOTS*SLOT_CYC cycles. GAP: tx_line=1 for GAP_SLOTS*SLOT_CYC cycles, then IDLE.
//  Byte counter is 8 bits and counts down from len; len=255 must not wrap.
//  sof_done asserted outside SOF_WAIT is ignored.
//  data_valid is ignored except in fetch cycles.
// CONFIGURATION
//  PPM_PARITY_EN defined: PAR state between DATA and EOF sends one extra byte, 4 symbols, no fetch cycle.
//   The byte is the XOR of all sent data bytes, cleared at SOF_REQ.
//   For len=0 or underrun, the XOR of the bytes actually sent (0x00 if none).
//  PPM_PARITY_EN undefined: no PAR state; DATA/SOF_WAIT go straight to EOF.
// TESTING
//  1. Reset mid-DATA: rst_n=0 one edge -> next cycle tx_line=1, busy=0, state IDLE; the next frame_start starts a clean frame.
//  2. len=1, byte 0xB4 (SLOT_CYC=16): control_sof pulses once; after sof_done, symbols 2,3,1,0.
//     Line low in slots 2,3,1,0 of each symbol; then 32 cycles low; then 64 high; busy drops.
//  3. len=3, data_valid held 1: exactly 3 data_ready handshakes, each 257 cycles apart; no err_underrun.
//  4. len=2, data_valid low at the 2nd fetch: err_underrun pulses once and EOF follows immediately.
//  5. frame_start pulsed during DATA and GAP -> ignored; len=0 -> SOF then EOF only, data_ready never asserted.
//  6. PPM_PARITY_EN, bytes 0x0F,0xF0 -> parity byte 0xFF: four symbols of value 3 before EOF.

Source files
------------

// File: rtl/ppm_frame_ctrl.sv
// ppm_frame_ctrl: PPM transmitter frame sequencer.
// Runs SOF request/wait, 4-PPM encodes the payload bytes, then sends EOF and an idle gap.
// Optional parity byte between payload and EOF when PPM_PARITY_EN is defined.
module ppm_frame_ctrl #(
  parameter int unsigned SLOT_CYC  = 16,
  parameter int unsigned EOF_SLOTS = 2,
  parameter int unsigned GAP_SLOTS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [7:0] frame_len,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       control_sof,
  input  logic       sof_in,
  input  logic       sof_done,
  output logic       tx_line,
  output logic       busy,
  output logic       err_underrun
);

  localparam int unsigned CYC_W   = $clog2(SLOT_CYC);
  localparam int unsigned EOF_CYC = EOF_SLOTS * SLOT_CYC;
  localparam int unsigned GAP_CYC = GAP_SLOTS * SLOT_CYC;
  localparam int unsigned TMR_MAX = (EOF_CYC > GAP_CYC) ? EOF_CYC : GAP_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SLOT_CYC - 1);
  localparam logic [TMR_W-1:0] EOF_LAST = TMR_W'(EOF_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SOF_REQ  = 3'd1,
    S_SOF_WAIT = 3'd2,
    S_DATA     = 3'd3,
    S_PAR      = 3'd4,
    S_EOF      = 3'd5,
    S_GAP      = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       bytes_q, bytes_d;
  logic [7:0]       shift_q, shift_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [1:0]       slot_q, slot_d;
  logic [1:0]       sym_q, sym_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tx_q, tx_d;
  logic             data_ready_q, data_ready_d;
  logic             control_sof_q, control_sof_d;
  logic             busy_q, busy_d;
  logic             err_underrun_q, err_underrun_d;
`ifdef PPM_PARITY_EN
  logic [7:0]       par_q, par_d;
  logic             to_eof;
`endif

  logic [CYC_W-1:0] step_cyc;
  logic [1:0]       step_slot;
  logic [1:0]       step_sym;
  logic [7:0]       step_shift;
  logic             step_tx;
  logic             byte_end;
  logic             to_tail;

  // Symbol engine: next slot position and line level while a byte is on the wire
  always_comb begin
    step_cyc   = cyc_q + CYC_W'(1);
    step_slot  = slot_q;
    step_sym   = sym_q;
    step_shift = shift_q;
    step_tx    = tx_q;
    byte_end   = 1'b0;
    if (cyc_q == CYC_LAST) begin
      step_cyc = '0;
      if (slot_q != 2'd3) begin
        step_slot = slot_q + 2'd1;
        step_tx   = ((slot_q + 2'd1) != shift_q[7:6]);
      end else begin
        step_slot = 2'd0;
        if (sym_q != 2'd3) begin
          step_sym   = sym_q + 2'd1;
          step_shift = {shift_q[5:0], 2'b00};
          step_tx    = (shift_q[5:4] != 2'd0);
        end else begin
          byte_end = 1'b1;
        end
      end
    end
  end

  // Frame FSM: next state, counters and registered outputs
  always_comb begin
    state_d        = state_q;
    bytes_d        = bytes_q;
    shift_d        = shift_q;
    cyc_d          = cyc_q;
    slot_d         = slot_q;
    sym_d          = sym_q;
    tmr_d          = tmr_q;
    tx_d           = tx_q;
    data_ready_d   = 1'b0;
    control_sof_d  = 1'b0;
    err_underrun_d = 1'b0;
    to_tail        = 1'b0;
`ifdef PPM_PARITY_EN
    par_d          = par_q;
    to_eof         = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (frame_start) begin
          bytes_d       = frame_len;
          control_sof_d = 1'b1;
          state_d       = S_SOF_REQ;
        end
      end
      S_SOF_REQ: begin
        tx_d    = 1'b1;
`ifdef PPM_PARITY_EN
        par_d   = 8'h00;
`endif
        state_d = S_SOF_WAIT;
      end
      S_SOF_WAIT: begin
        tx_d = 1'b1;
        if (sof_done) begin
          if (bytes_q != 8'd0) begin
            state_d      = S_DATA;
            data_ready_d = 1'b1;
          end else begin
            to_tail = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (data_ready_q) begin
          if (data_valid) begin
            shift_d = data_in;
            bytes_d = bytes_q - 8'd1;
            cyc_d   = '0;
            slot_d  = 2'd0;
            sym_d   = 2'd0;
            tx_d    = (data_in[7:6] != 2'd0);
`ifdef PPM_PARITY_EN
            par_d   = par_q ^ data_in;
`endif
          end else begin
            err_underrun_d = 1'b1;
            to_tail        = 1'b1;
          end
        end else begin
          cyc_d   = step_cyc;
          slot_d  = step_slot;
          sym_d   = step_sym;
          shift_d = step_shift;
          tx_d    = step_tx;
          if (byte_end) begin
            if (bytes_q == 8'd0) begin
              to_tail = 1'b1;
            end else begin
              data_ready_d = 1'b1;
              tx_d         = 1'b1;
            end
          end
        end
      end
`ifdef PPM_PARITY_EN
      S_PAR: begin
        cyc_d   = step_cyc;
        slot_d  = step_slot;
        sym_d   = step_sym;
        shift_d = step_shift;
        tx_d    = step_tx;
        if (byte_end) begin
          to_eof = 1'b1;
        end
      end
`endif
      S_EOF: begin
        if (tmr_q == EOF_LAST) begin
          tmr_d   = '0;
          tx_d    = 1'b1;
          state_d = S_GAP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
          tx_d  = 1'b0;
        end
      end
      S_GAP: begin
        tx_d = 1'b1;
        if (tmr_q == GAP_LAST) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Payload finished (or never started): parity byte if enabled, else EOF
`ifdef PPM_PARITY_EN
    if (to_tail) begin
      state_d = S_PAR;
      shift_d = par_q;
      cyc_d   = '0;
      slot_d  = 2'd0;
      sym_d   = 2'd0;
      tx_d    = (par_q[7:6] != 2'd0);
    end
    if (to_eof) begin
      state_d = S_EOF;
      tmr_d   = '0;
      tx_d    = 1'b0;
    end
`else
    if (to_tail) begin
      state_d = S_EOF;
      tmr_d   = '0;
      tx_d    = 1'b0;
    end
`endif

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      bytes_q        <= 8'd0;
      shift_q        <= 8'd0;
      cyc_q          <= '0;
      slot_q         <= 2'd0;
      sym_q          <= 2'd0;
      tmr_q          <= '0;
      tx_q           <= 1'b1;
      data_ready_q   <= 1'b0;
      control_sof_q  <= 1'b0;
      busy_q         <= 1'b0;
      err_underrun_q <= 1'b0;
`ifdef PPM_PARITY_EN
      par_q          <= 8'h00;
`endif
    end else begin
      state_q        <= state_d;
      bytes_q        <= bytes_d;
      shift_q        <= shift_d;
      cyc_q          <= cyc_d;
      slot_q         <= slot_d;
      sym_q          <= sym_d;
      tmr_q          <= tmr_d;
      tx_q           <= tx_d;
      data_ready_q   <= data_ready_d;
      control_sof_q  <= control_sof_d;
      busy_q         <= busy_d;
      err_underrun_q <= err_underrun_d;
`ifdef PPM_PARITY_EN
      par_q          <= par_d;
`endif
    end
  end

  // SOF generator owns the line only while we wait for it
  assign tx_line      = (state_q == S_SOF_WAIT) ? sof_in : tx_q;
  assign data_ready   = data_ready_q;
  assign control_sof  = control_sof_q;
  assign busy         = busy_q;
  assign err_underrun = err_underrun_q;

endmodule
